// File: rtl/ram_dp_ext.sv
`default_nettype none
// ============================================================================
// Module   : ram_dp_ext
// Brief    : Single-clock true-dual-port RAM with byte enables, read-valid
//            strobes, optional output register and a constant-fill clear engine.
// Revision : 1.0 - initial release
// ============================================================================
module ram_dp_ext #(
    parameter int              DW         = 8,
    parameter int              AW         = 16,
    parameter int              OUT_REG    = 0,
    parameter int              CLR_ON_RST = 1,
    parameter logic [DW-1:0]   CLR_VAL    = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce_a,
    input  logic               we_a,
    input  logic [DW/8-1:0]    be_a,
    input  logic [AW-1:0]      addr_a,
    input  logic [DW-1:0]      dati_a,
    output logic [DW-1:0]      dato_a,
    output logic               rv_a,
    input  logic               ce_b,
    input  logic               we_b,
    input  logic [DW/8-1:0]    be_b,
    input  logic [AW-1:0]      addr_b,
    input  logic [DW-1:0]      dati_b,
    output logic [DW-1:0]      dato_b,
    output logic               rv_b,
    input  logic               clr,
    output logic               busy
);

    localparam int            c_BW       = DW / 8;
    localparam int            c_DEPTH    = 2 ** AW;
    localparam logic [AW-1:0] c_CNT_LAST = {AW{1'b1}};
    localparam logic          c_CLR_RST  = (CLR_ON_RST != 0);

    localparam logic [0:0]    c_S_IDLE   = 1'b0;
    localparam logic [0:0]    c_S_CLEAR  = 1'b1;

    logic [DW-1:0]   r_mem [c_DEPTH];
    logic [0:0]      r_state;
    logic [0:0]      w_state_nxt;
    logic [AW-1:0]   r_cnt;

    logic            w_busy;
    logic            w_clr_wr;
    logic            w_acc_a;
    logic            w_acc_b;
    logic [c_BW-1:0] w_be_a;
    logic [c_BW-1:0] w_be_b;

    logic [DW-1:0]   r_dout_a;
    logic [DW-1:0]   r_dout_b;
    logic            r_rv_a;
    logic            r_rv_b;

    // Overlay the enabled bytes of new_w onto old_w.
    function automatic logic [DW-1:0] f_merge(input logic [DW-1:0]   old_w,
                                              input logic [DW-1:0]   new_w,
                                              input logic [c_BW-1:0] be);
        f_merge = old_w;
        for (int i = 0; i < c_BW; i++) begin
            if (be[i]) f_merge[8*i +: 8] = new_w[8*i +: 8];
        end
    endfunction

    // During reset busy reflects the state the engine will take on release.
    assign w_busy   = rst ? c_CLR_RST : (r_state == c_S_CLEAR);
    assign busy     = w_busy;
    assign w_clr_wr = !rst && (r_state == c_S_CLEAR);
    assign w_acc_a  = ce_a && !w_busy;
    assign w_acc_b  = ce_b && !w_busy;
    assign w_be_a   = we_a ? be_a : '0;
    assign w_be_b   = we_b ? be_b : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_CLR_RST ? c_S_CLEAR : c_S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= (r_state == c_S_CLEAR) ? r_cnt + AW'(1) : '0;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (clr) w_state_nxt = c_S_CLEAR;
            c_S_CLEAR: if (r_cnt == c_CNT_LAST) w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    // Array has no reset; on a same-address collision A owns its enabled bytes.
    always_ff @(posedge clk) begin
        if (w_clr_wr) begin
            r_mem[r_cnt] <= CLR_VAL;
        end else begin
            for (int i = 0; i < c_BW; i++) begin
                if (w_acc_b && w_be_b[i] &&
                    !(w_acc_a && w_be_a[i] && (addr_a == addr_b)))
                    r_mem[addr_b][8*i +: 8] <= dati_b[8*i +: 8];
                if (w_acc_a && w_be_a[i])
                    r_mem[addr_a][8*i +: 8] <= dati_a[8*i +: 8];
            end
        end
    end

    // Each port sees old content merged with its own write bytes only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout_a <= '0;
            r_dout_b <= '0;
            r_rv_a   <= 1'b0;
            r_rv_b   <= 1'b0;
        end else begin
            r_rv_a <= w_acc_a;
            r_rv_b <= w_acc_b;
            if (w_acc_a) r_dout_a <= f_merge(r_mem[addr_a], dati_a, w_be_a);
            if (w_acc_b) r_dout_b <= f_merge(r_mem[addr_b], dati_b, w_be_b);
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DW-1:0] r_pipe_a;
            logic [DW-1:0] r_pipe_b;
            logic          r_pipe_rv_a;
            logic          r_pipe_rv_b;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pipe_a    <= '0;
                    r_pipe_b    <= '0;
                    r_pipe_rv_a <= 1'b0;
                    r_pipe_rv_b <= 1'b0;
                end else begin
                    r_pipe_a    <= r_dout_a;
                    r_pipe_b    <= r_dout_b;
                    r_pipe_rv_a <= r_rv_a;
                    r_pipe_rv_b <= r_rv_b;
                end
            end

            assign dato_a = r_pipe_a;
            assign dato_b = r_pipe_b;
            assign rv_a   = r_pipe_rv_a;
            assign rv_b   = r_pipe_rv_b;
        end else begin : g_out_direct
            assign dato_a = r_dout_a;
            assign dato_b = r_dout_b;
            assign rv_a   = r_rv_a;
            assign rv_b   = r_rv_b;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_ram_dp_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_dp_ext
// Brief    : Self-checking bench for ram_dp_ext (1- and 2-cycle latency builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_dp_ext;

    localparam int          c_AW    = 4;
    localparam int          c_DW    = 16;
    localparam int          c_DEPTH = 16;
    localparam logic [15:0] c_CLR   = 16'hA5A5;

    logic        clk;
    logic        rst, clr;
    logic        ce_a, we_a, ce_b, we_b;
    logic [1:0]  be_a, be_b;
    logic [3:0]  addr_a, addr_b;
    logic [15:0] dati_a, dati_b;

    logic [15:0] dato_a0, dato_b0, dato_a1, dato_b1;
    logic        rv_a0, rv_b0, rv_a1, rv_b1, busy0, busy1;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model state
    logic [15:0] m_mem [c_DEPTH];
    int          m_left = 0;
    logic [15:0] m_da = 0, m_db = 0, m_pa = 0, m_pb = 0;
    logic        m_ra = 0, m_rb = 0, m_pra = 0, m_prb = 0;

    ram_dp_ext #(.DW(c_DW), .AW(c_AW), .OUT_REG(0), .CLR_ON_RST(1), .CLR_VAL(c_CLR)) dut0 (
        .clk(clk), .rst(rst),
        .ce_a(ce_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .dati_a(dati_a),
        .dato_a(dato_a0), .rv_a(rv_a0),
        .ce_b(ce_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .dati_b(dati_b),
        .dato_b(dato_b0), .rv_b(rv_b0),
        .clr(clr), .busy(busy0)
    );

    ram_dp_ext #(.DW(c_DW), .AW(c_AW), .OUT_REG(1), .CLR_ON_RST(1), .CLR_VAL(c_CLR)) dut1 (
        .clk(clk), .rst(rst),
        .ce_a(ce_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .dati_a(dati_a),
        .dato_a(dato_a1), .rv_a(rv_a1),
        .ce_b(ce_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .dati_b(dati_b),
        .dato_b(dato_b1), .rv_b(rv_b1),
        .clr(clr), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ce_a, we_a; logic [1:0] be_a; logic [3:0] addr_a; logic [15:0] dati_a;
        logic        ce_b, we_b; logic [1:0] be_b; logic [3:0] addr_b; logic [15:0] dati_b;
        logic        rv_a; logic [15:0] da;
        logic        rv_b; logic [15:0] db;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [15:0] merge(input logic [15:0] o, input logic [15:0] n,
                                          input logic [1:0] be);
        logic [15:0] r;
        r = o;
        if (be[0]) r[7:0]  = n[7:0];
        if (be[1]) r[15:8] = n[15:8];
        return r;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        clr = 0;
        ce_a = 0; we_a = 0; be_a = 0; addr_a = 0; dati_a = 0;
        ce_b = 0; we_b = 0; be_b = 0; addr_b = 0; dati_b = 0;
    endtask

    // Apply the current inputs across one clock edge and check both builds.
    task automatic step();
        logic [15:0] oa, ob;
        if (rst) begin
            m_da = 0; m_db = 0; m_ra = 0; m_rb = 0;
            m_pa = 0; m_pb = 0; m_pra = 0; m_prb = 0;
            m_left = c_DEPTH;
        end else begin
            m_pa = m_da; m_pb = m_db; m_pra = m_ra; m_prb = m_rb;
            m_ra = 0; m_rb = 0;
            if (m_left > 0) begin
                m_mem[c_DEPTH - m_left] = c_CLR;
                m_left--;
            end else begin
                oa = m_mem[addr_a];
                ob = m_mem[addr_b];
                if (ce_a) begin m_da = merge(oa, dati_a, we_a ? be_a : 2'b00); m_ra = 1; end
                if (ce_b) begin m_db = merge(ob, dati_b, we_b ? be_b : 2'b00); m_rb = 1; end
                if (ce_b && we_b) m_mem[addr_b] = merge(m_mem[addr_b], dati_b, be_b);
                if (ce_a && we_a) m_mem[addr_a] = merge(m_mem[addr_a], dati_a, be_a);
                if (clr) m_left = c_DEPTH;
            end
        end
        @(posedge clk);
        #1;
        chk("busy0", {15'd0, busy0}, {15'd0, m_left > 0});
        chk("busy1", {15'd0, busy1}, {15'd0, m_left > 0});
        chk("rv_a0", {15'd0, rv_a0}, {15'd0, m_ra});
        chk("rv_b0", {15'd0, rv_b0}, {15'd0, m_rb});
        chk("dato_a0", dato_a0, m_da);
        chk("dato_b0", dato_b0, m_db);
        chk("rv_a1", {15'd0, rv_a1}, {15'd0, m_pra});
        chk("rv_b1", {15'd0, rv_b1}, {15'd0, m_prb});
        chk("dato_a1", dato_a1, m_pa);
        chk("dato_b1", dato_b1, m_pb);
    endtask

    initial begin
        int n, rvc, first;
        for (int i = 0; i < c_DEPTH; i++) m_mem[i] = 16'h0;

        //                ceA weA beA  adA datA      ceB weB beB  adB datB      rvA dA        rvB dB
        tbl[0]  = '{1, 1, 2'b11, 3, 16'h1234, 0, 0, 2'b00, 0, 16'h0000, 1, 16'h1234, 0, 16'h0000};
        tbl[1]  = '{1, 1, 2'b10, 3, 16'hFF00, 0, 0, 2'b00, 0, 16'h0000, 1, 16'hFF34, 0, 16'h0000};
        tbl[2]  = '{0, 0, 2'b00, 0, 16'h0000, 1, 0, 2'b00, 3, 16'h0000, 0, 16'h0000, 1, 16'hFF34};
        tbl[3]  = '{1, 1, 2'b11, 5, 16'h0000, 1, 1, 2'b11, 7, 16'h0000, 1, 16'h0000, 1, 16'h0000};
        tbl[4]  = '{1, 1, 2'b01, 5, 16'h1111, 1, 1, 2'b11, 5, 16'h2222, 1, 16'h0011, 1, 16'h2222};
        tbl[5]  = '{1, 0, 2'b00, 5, 16'h0000, 1, 0, 2'b00, 5, 16'h0000, 1, 16'h2211, 1, 16'h2211};
        tbl[6]  = '{1, 1, 2'b11, 7, 16'hBEEF, 1, 0, 2'b00, 7, 16'h0000, 1, 16'hBEEF, 1, 16'h0000};
        tbl[7]  = '{0, 0, 2'b00, 0, 16'h0000, 1, 0, 2'b00, 7, 16'h0000, 0, 16'h0000, 1, 16'hBEEF};
        tbl[8]  = '{1, 1, 2'b00, 3, 16'hFFFF, 1, 0, 2'b00, 3, 16'h0000, 1, 16'hFF34, 1, 16'hFF34};
        tbl[9]  = '{1, 0, 2'b00, 3, 16'h0000, 0, 0, 2'b00, 0, 16'h0000, 1, 16'hFF34, 0, 16'h0000};
        tbl[10] = '{0, 0, 2'b00, 0, 16'h0000, 0, 0, 2'b00, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000};

        idle();
        rst = 1;
        repeat (3) step();
        chk("reset_dato_a0", dato_a0, 16'h0000);
        chk("reset_busy0", {15'd0, busy0}, 16'h0001);

        // Clear after reset release: busy must fall on the 16th edge.
        rst = 0;
        n = 0;
        while (n < 40) begin step(); n++; if (!busy0) break; end
        chk("clr_after_rst_len", 16'(n), 16'd16);

        for (int a = 0; a < c_DEPTH; a++) begin
            ce_a = 1; addr_a = 4'(a); ce_b = 1; addr_b = 4'(15 - a);
            step();
            chk("init_read_a", dato_a0, c_CLR);
            chk("init_read_b", dato_b0, c_CLR);
            idle();
            step();
            chk("idle_rv_a", {15'd0, rv_a0}, 16'h0000);
        end

        // Directed vector table on the 1-cycle build.
        for (int i = 0; i < 11; i++) begin
            ce_a = tbl[i].ce_a; we_a = tbl[i].we_a; be_a = tbl[i].be_a;
            addr_a = tbl[i].addr_a; dati_a = tbl[i].dati_a;
            ce_b = tbl[i].ce_b; we_b = tbl[i].we_b; be_b = tbl[i].be_b;
            addr_b = tbl[i].addr_b; dati_b = tbl[i].dati_b;
            step();
            chk($sformatf("tbl%0d_rv_a", i), {15'd0, rv_a0}, {15'd0, tbl[i].rv_a});
            chk($sformatf("tbl%0d_rv_b", i), {15'd0, rv_b0}, {15'd0, tbl[i].rv_b});
            if (tbl[i].rv_a) chk($sformatf("tbl%0d_dato_a", i), dato_a0, tbl[i].da);
            if (tbl[i].rv_b) chk($sformatf("tbl%0d_dato_b", i), dato_b0, tbl[i].db);
        end
        idle();

        // Pipelined build: four back-to-back reads appear two edges later.
        rvc = 0; first = 0;
        for (int j = 1; j <= 7; j++) begin
            if (j <= 4) begin ce_a = 1; addr_a = 4'(j - 1); end
            else idle();
            step();
            if (rv_a1) begin rvc++; if (first == 0) first = j; end
        end
        chk("pipe_rv_count", 16'(rvc), 16'd4);
        chk("pipe_first_rv", 16'(first), 16'd2);
        chk("pipe_last_data", dato_a1, 16'hFF34);

        // Randomized traffic, including occasional clear requests.
        for (int k = 0; k < 400; k++) begin
            ce_a = 1'($urandom_range(0, 1)); we_a = 1'($urandom_range(0, 1));
            be_a = 2'($urandom); addr_a = 4'($urandom); dati_a = 16'($urandom);
            ce_b = 1'($urandom_range(0, 1)); we_b = 1'($urandom_range(0, 1));
            be_b = 2'($urandom); addr_b = 4'($urandom); dati_b = 16'($urandom);
            clr = ($urandom_range(0, 59) == 0);
            step();
        end
        idle();
        n = 0;
        while (busy0 && n < 40) begin step(); n++; end
        chk("drain_busy", {15'd0, busy0}, 16'h0000);

        // Reset in mid-clear restarts; clr and writes during busy have no effect.
        clr = 1;
        step();
        clr = 0;
        repeat (8) step();
        rst = 1;
        repeat (2) step();
        rst = 0;
        n = 0;
        while (n < 40) begin
            idle();
            if (n == 3) clr = 1;
            if (n == 5 || n == 6) begin
                ce_a = 1; we_a = 1; be_a = 2'b11; addr_a = 2; dati_a = 16'h7777;
            end
            step();
            n++;
            if (!busy0) break;
        end
        chk("restart_clr_len", 16'(n), 16'd16);
        idle();
        ce_a = 1; addr_a = 2;
        step();
        chk("busy_write_lost", dato_a0, c_CLR);
        idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
